// File: rtl/dff_shift_pkg.sv
// Shared encodings for the universal shift register.
package dff_shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ASR  = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/dff_en_ar.sv
// WIDTH-bit D register with clock enable and asynchronous active-high reset.
module dff_en_ar #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on enabled edges; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dff_shift_reg.sv
// Universal shift register: load, clear and multi-step shift/rotate
// operations started with a start/busy/done handshake.
module dff_shift_reg
  import dff_shift_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    cnt,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_t        state, state_nxt;
  op_t           op_r, op_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic          sout_nxt;
  logic [CW-1:0] rem, rem_nxt;
  logic [CW-1:0] cnt_sat;
  logic          done_evt;

  // One shift/rotate step: returns {bit leaving q, new q}.
  function automatic logic [WIDTH:0] step(op_t o, logic [WIDTH-1:0] v,
                                          logic s, logic so);
    case (o)
      OP_SHL:  return {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SHR:  return {v[0], s, v[WIDTH-1:1]};
      OP_ROL:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  return {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: return {so, v};
    endcase
  endfunction

  assign cnt_sat = (cnt > WMAX) ? WMAX : cnt;
  assign busy    = (state == ST_SHIFT);

  dff_en_ar #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_q (
    .clk(clk), .reset(reset), .en(en), .d(q_nxt), .q(q)
  );

  dff_en_ar #(.WIDTH(1), .RESET_VAL(1'b0)) u_sout (
    .clk(clk), .reset(reset), .en(en), .d(sout_nxt), .q(sout)
  );

  dff_en_ar #(.WIDTH(CW), .RESET_VAL('0)) u_rem (
    .clk(clk), .reset(reset), .en(en), .d(rem_nxt), .q(rem)
  );

  // FSM state and the operation latched on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_r  <= OP_NOP;
    end else if (en) begin
      state <= state_nxt;
      op_r  <= op_nxt;
    end
  end

  // done is a single-cycle pulse: it clears on the next edge even with en low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= en & done_evt;
  end

  // Next-state, next-q, serial-out and step-count logic.
  // The accepting edge performs the first step itself, so rem holds the
  // steps still outstanding once SHIFT is entered.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    q_nxt     = q;
    sout_nxt  = sout;
    rem_nxt   = rem;
    done_evt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          op_nxt = op_t'(op);
          case (op_t'(op))
            OP_NOP:  done_evt = 1'b1;
            OP_LOAD: begin
              q_nxt    = din;
              done_evt = 1'b1;
            end
            OP_CLR: begin
              q_nxt    = RESET_VAL;
              done_evt = 1'b1;
            end
            default: begin
              if (cnt_sat == '0) begin
                done_evt = 1'b1;
              end else begin
                {sout_nxt, q_nxt} = step(op_t'(op), q, sin, sout);
                rem_nxt = cnt_sat - CW'(1);
                if (cnt_sat == CW'(1)) done_evt  = 1'b1;
                else                   state_nxt = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        {sout_nxt, q_nxt} = step(op_r, q, sin, sout);
        rem_nxt = rem - CW'(1);
        if (rem == CW'(1)) begin
          state_nxt = ST_IDLE;
          done_evt  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_dff_shift_reg.sv
// Directed and randomized checks of dff_shift_reg against an arithmetic model.
module tb_dff_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic         start;
  logic [2:0]   op;
  logic [3:0]   cnt;
  logic         sin;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic         sout;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  int m_q;     // model register value (0..255)
  int m_sout;  // model serial-out bit

  dff_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .op(op), .cnt(cnt),
    .sin(sin), .din(din), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of one shift/rotate step using plain integer arithmetic.
  task automatic mstep(input int o, input int s);
    int v;
    v = m_q;
    case (o)
      2: begin m_sout = v / 128; m_q = (v * 2 + s) % 256; end
      3: begin m_sout = v % 2;   m_q = v / 2 + s * 128; end
      4: begin m_sout = v / 128; m_q = (v * 2) % 256 + v / 128; end
      5: begin m_sout = v % 2;   m_q = v / 2 + (v % 2) * 128; end
      6: begin m_sout = v % 2;   m_q = v / 2 + (v / 128) * 128; end
      default: ;
    endcase
  endtask

  task automatic chk_state(input string tag, input int exp_busy, input int exp_done);
    chk({tag, "_q"},    32'(q),    32'(m_q));
    chk({tag, "_sout"}, 32'(sout), 32'(m_sout));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // Issue one op; mask bit i gives en on the i-th cycle after acceptance.
  // sin_fix < 0 means random serial input each step.
  task automatic run_op(input string tag, input int opc, input int c,
                        input logic [7:0] d, input int sin_fix,
                        input logic [31:0] mask, output int busy_cycles);
    int n, steps, it, s;
    logic e;
    n = (opc >= 2 && opc <= 6) ? ((c > 8) ? 8 : c) : 0;
    busy_cycles = 0;
    s = (sin_fix < 0) ? int'($urandom_range(0, 1)) : sin_fix;
    en = 1'b1; start = 1'b1; op = 3'(opc); cnt = 4'(c); din = d; sin = 1'(s);
    tick();
    start = 1'b0;
    case (opc)
      1: m_q = int'(d);
      7: m_q = 0;
      default: if (n > 0) mstep(opc, s);
    endcase
    steps = (n > 0) ? 1 : 0;
    if (busy) busy_cycles++;
    chk_state({tag, "_acc"}, (n > 1) ? 1 : 0, (n <= 1) ? 1 : 0);
    it = 0;
    while (steps < n && it < 64) begin
      e = (it < 32) ? mask[it] : 1'b1;
      s = (sin_fix < 0) ? int'($urandom_range(0, 1)) : sin_fix;
      en = e; sin = 1'(s);
      start = 1'($urandom_range(0, 1)); op = 3'd1; din = 8'($urandom);
      tick();
      if (e) begin
        mstep(opc, s);
        steps++;
      end
      if (busy) busy_cycles++;
      chk_state({tag, "_stp"}, (steps < n) ? 1 : 0, (e && steps == n) ? 1 : 0);
      it++;
    end
    if (steps < n) chk({tag, "_timeout"}, 32'(steps), 32'(n));
    start = 1'b0;
    en = 1'($urandom_range(0, 1));
    tick();
    chk_state({tag, "_post"}, 0, 0);
    en = 1'b1;
  endtask

  initial begin
    int bc;
    reset = 1'b1; en = 1'b0; start = 1'b0; op = 3'd0; cnt = 4'd0;
    sin = 1'b0; din = 8'h00;
    m_q = 0; m_sout = 0;
    #12;
    chk_state("reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // LOAD: single-cycle, never busy.
    run_op("load", 1, 0, 8'hA5, 0, '1, bc);
    chk("load_busy_cycles", 32'(bc), 32'd0);
    chk("load_val", 32'(q), 32'h00A5);

    // SHL by 3 with sin=1: A5 -> 4B -> 97 -> 2F.
    run_op("shl3", 2, 3, 8'h00, 1, '1, bc);
    chk("shl3_busy_cycles", 32'(bc), 32'd2);
    chk("shl3_final", 32'(q), 32'h002F);
    chk("shl3_sout", 32'(sout), 32'd1);

    // ASR with saturated count.
    run_op("ld80", 1, 0, 8'h80, 0, '1, bc);
    run_op("asr9", 6, 9, 8'h00, 0, '1, bc);
    chk("asr9_busy_cycles", 32'(bc), 32'd7);
    chk("asr9_final", 32'(q), 32'h00FF);

    // ROR by 4 with a two-cycle stall after step 2; LOAD requests ignored.
    run_op("ldA5", 1, 0, 8'hA5, 0, '1, bc);
    run_op("ror4", 5, 4, 8'h00, -1, 32'h0000_0019, bc);
    chk("ror4_busy_cycles", 32'(bc), 32'd5);
    chk("ror4_final", 32'(q), 32'h005A);

    // Rotate by full width restores the value; cnt=0 acts as NOP.
    run_op("rol8", 4, 8, 8'h00, -1, '1, bc);
    chk("rol8_final", 32'(q), 32'h005A);
    run_op("shr0", 3, 0, 8'h00, 1, '1, bc);
    chk("shr0_final", 32'(q), 32'h005A);

    // Abort: reset during SHL cnt=5 after step 2.
    en = 1'b1; start = 1'b1; op = 3'd2; cnt = 4'd5; sin = 1'b1;
    tick();
    start = 1'b0;
    mstep(2, 1);
    tick();
    mstep(2, 1);
    chk_state("abort_pre", 1, 0);
    #2;
    reset = 1'b1;
    #1;
    m_q = 0; m_sout = 0;
    chk_state("abort_rst", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_state("abort_after", 0, 0);
    run_op("reload", 1, 0, 8'hA5, 0, '1, bc);
    chk("reload_busy_cycles", 32'(bc), 32'd0);

    // Randomized ops with random stalls.
    for (int i = 0; i < 60; i++) begin
      run_op("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             8'($urandom), -1, $urandom | 32'h8000_0000, bc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
